// File: rtl/dspl_capture_if.sv
// Bus bundle between a multiplexed 7-segment display scan and dspl_capture.
// The master side drives the scan (an/dec_cat) and observes the decoded
// frame; the slave side is the capture block itself.
//
// Handshake: frame_valid is a one-cycle pulse with no back-pressure. digits
// changes only in the cycle frame_valid is high and holds its value otherwise.
// The consumer must take the frame in that cycle; there is no ready signal.
// fsm_state is a debug view of the capture FSM (0 = IDLE, 1 = DWELL, 2 = HELD).
interface dspl_capture_if;
    logic [7:0]  an;
    logic [7:0]  dec_cat;
    logic [47:0] digits;
    logic        frame_valid;
    logic        seg_error;
    logic        anode_error;
    logic        display_idle;
    logic [1:0]  fsm_state;

    modport master (
        output an,
        output dec_cat,
        input  digits,
        input  frame_valid,
        input  seg_error,
        input  anode_error,
        input  display_idle,
        input  fsm_state
    );

    modport slave (
        input  an,
        input  dec_cat,
        output digits,
        output frame_valid,
        output seg_error,
        output anode_error,
        output display_idle,
        output fsm_state
    );
endinterface

// File: rtl/dspl_capture.sv
// dspl_capture: receive-side decoder for an 8-digit multiplexed 7-segment
// bus. Each digit dwell is tracked until the sample has been stable for
// STABLE_CYCLES, then it is decoded into {en, hex[3:0], dp} and stored in a
// shadow frame. The frame is published when a digit that was already
// captured in this frame comes round again.
//
// Optional macro SYNC_INPUTS_EN: when defined, an/dec_cat pass through a
// two-flop synchronizer first (all latencies grow by two cycles). When
// undefined, the inputs are assumed synchronous to clock.
module dspl_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic          clock,
    input  logic          reset,
    dspl_capture_if.slave bus
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]        STAB_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input sampling
    // ------------------------------------------------------------------
    logic [7:0] an_s;
    logic [7:0] cat_s;

`ifdef SYNC_INPUTS_EN
    logic [15:0] sync_a;
    logic [15:0] sync_b;

    // Two-flop synchronizer; resets to a blank sample so nothing is seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= {bus.an, bus.dec_cat};
            sync_b <= sync_a;
        end
    end

    assign an_s  = sync_b[15:8];
    assign cat_s = sync_b[7:0];
`else
    assign an_s  = bus.an;
    assign cat_s = bus.dec_cat;
`endif

    logic [7:0] an_low;
    logic       no_low;
    logic       one_low;
    logic       multi_low;
    logic [2:0] samp_idx;

    assign an_low    = ~an_s;
    assign no_low    = (an_s == 8'hFF);
    assign one_low   = !no_low && ((an_low & (an_low - 8'd1)) == 8'd0);
    assign multi_low = !no_low && !one_low;

    // Position of the low anode bit; only meaningful when exactly one is low.
    always_comb begin
        samp_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) samp_idx = 3'(i);
        end
    end

    // Segment pattern (active-high, bit 6 = a ... bit 0 = g) to {bad, hex}.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg_on);
        case (seg_on)
            7'h7E:   decode_glyph = 5'h00;
            7'h30:   decode_glyph = 5'h01;
            7'h6D:   decode_glyph = 5'h02;
            7'h79:   decode_glyph = 5'h03;
            7'h33:   decode_glyph = 5'h04;
            7'h5B:   decode_glyph = 5'h05;
            7'h5F:   decode_glyph = 5'h06;
            7'h70:   decode_glyph = 5'h07;
            7'h7F:   decode_glyph = 5'h08;
            7'h7B:   decode_glyph = 5'h09;
            7'h77:   decode_glyph = 5'h0A;
            7'h1F:   decode_glyph = 5'h0B;
            7'h4E:   decode_glyph = 5'h0C;
            7'h3D:   decode_glyph = 5'h0D;
            7'h4F:   decode_glyph = 5'h0E;
            7'h47:   decode_glyph = 5'h0F;
            default: decode_glyph = 5'h10;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    state_t     state;
    state_t     nxt_state;
    logic [2:0] cur_idx;
    logic [7:0] cur_cat;
    logic [7:0] stab_cnt;
    logic       load_cur;
    logic       inc_cnt;
    logic       capture;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= nxt_state;
    end

    // Next state and tracking controls; a multi-anode sample acts as blank.
    always_comb begin
        nxt_state = state;
        load_cur  = 1'b0;
        inc_cnt   = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (one_low) begin
                    nxt_state = ST_DWELL;
                    load_cur  = 1'b1;
                end
            end
            ST_DWELL: begin
                if (!one_low) begin
                    nxt_state = ST_IDLE;
                end else if (samp_idx != cur_idx || cat_s != cur_cat) begin
                    load_cur = 1'b1;
                end else if (stab_cnt == STAB_LAST) begin
                    capture   = 1'b1;
                    nxt_state = ST_HELD;
                end else begin
                    inc_cnt = 1'b1;
                end
            end
            ST_HELD: begin
                if (!one_low) begin
                    nxt_state = ST_IDLE;
                end else if (samp_idx != cur_idx) begin
                    nxt_state = ST_DWELL;
                    load_cur  = 1'b1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Digit under observation and its stability count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_idx  <= 3'd0;
            cur_cat  <= 8'hFF;
            stab_cnt <= 8'd0;
        end else if (load_cur) begin
            cur_idx  <= samp_idx;
            cur_cat  <= cat_s;
            stab_cnt <= 8'd1;
        end else if (inc_cnt) begin
            stab_cnt <= stab_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly and idle timeout
    // ------------------------------------------------------------------
    logic [IDLE_W-1:0] idle_cnt;
    logic [5:0]        shadow [8];
    logic [7:0]        seen;
    logic [47:0]       digits_q;
    logic              frame_valid_q;
    logic              seg_error_q;
    logic              anode_error_q;
    logic              display_idle_q;

    logic [4:0]  decoded;
    logic [5:0]  cap_field;
    logic [47:0] frame_out;
    logic [47:0] digits_off;
    logic        timeout_hit;

    assign decoded     = decode_glyph(~cur_cat[7:1]);
    assign cap_field   = {1'b1, decoded[3:0], ~cur_cat[0]};
    // Only a display that was live can time out, so the pulse fires once.
    assign timeout_hit = no_low && (idle_cnt == IDLE_LAST) && !display_idle_q;

    // Published frame: shadow contents, with slots not seen this frame disabled.
    always_comb begin
        frame_out  = '0;
        digits_off = digits_q;
        for (int i = 0; i < 8; i++) begin
            frame_out[i*6 +: 6] = {seen[i] & shadow[i][5], shadow[i][4:0]};
            digits_off[i*6 + 5] = 1'b0;
        end
    end

    // Count consecutive cycles with no anode driven low; saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                idle_cnt <= '0;
        else if (!no_low)          idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 1'b1;
    end

    // Shadow frame, seen mask, published digits and status flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) shadow[i] <= 6'd0;
            seen           <= 8'd0;
            digits_q       <= 48'd0;
            frame_valid_q  <= 1'b0;
            seg_error_q    <= 1'b0;
            anode_error_q  <= 1'b0;
            display_idle_q <= 1'b1;
        end else begin
            frame_valid_q <= 1'b0;
            if (multi_low) anode_error_q <= 1'b1;
            if (capture) begin
                display_idle_q   <= 1'b0;
                shadow[cur_idx]  <= cap_field;
                if (decoded[4]) seg_error_q <= 1'b1;
                if (seen[cur_idx]) begin
                    // Repeat of a digit closes the frame; it opens the next one.
                    digits_q      <= frame_out;
                    frame_valid_q <= 1'b1;
                    seen          <= 8'b1 << cur_idx;
                end else begin
                    seen[cur_idx] <= 1'b1;
                end
            end else if (timeout_hit) begin
                display_idle_q <= 1'b1;
                digits_q       <= digits_off;
                frame_valid_q  <= 1'b1;
                seen           <= 8'd0;
            end
        end
    end

    assign bus.digits       = digits_q;
    assign bus.frame_valid  = frame_valid_q;
    assign bus.seg_error    = seg_error_q;
    assign bus.anode_error  = anode_error_q;
    assign bus.display_idle = display_idle_q;
    assign bus.fsm_state    = state;

endmodule

// File: tb/tb_dspl_capture.sv
// Bench for dspl_capture: directed scenarios followed by a randomized scan.
// Stimulus is issued one digit dwell at a time; a dwell-level model predicts
// each published frame and pushes it to exp_q; the monitor pops on frame_valid.
module tb_dspl_capture;
    localparam int S = 16;
    localparam int T = 64;

    logic clock;
    logic reset;

    int n_vec = 0;
    int n_err = 0;
    logic [48:0] exp_q[$];   // {display_idle, digits}

    // Hex glyphs as active-high segments, bit 6 = a ... bit 0 = g.
    logic [6:0] glyph [16];

    // Reference model state.
    logic [5:0]  m_shadow [8];
    logic [7:0]  m_seen;
    logic [47:0] m_digits;
    logic        m_idle;
    logic        m_seg;
    logic        m_anerr;
    int          m_blank_run;

    dspl_capture_if bus();

    dspl_capture #(
        .STABLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Overall time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: bench still running at time %0t, limit 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] c);
        @(negedge clock);
        bus.an      = a;
        bus.dec_cat = c;
    endtask

    function automatic logic [7:0] glyph_cat(input int h, input logic dp);
        return {~glyph[h], ~dp};
    endfunction

    task automatic bad_cat(output logic [7:0] c);
        logic [6:0] seg;
        logic       hit;
        do begin
            seg = 7'($urandom);
            hit = 1'b0;
            for (int h = 0; h < 16; h++) if (glyph[h] == seg) hit = 1'b1;
        end while (hit);
        c = {~seg, 1'($urandom)};
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_shadow[i] = 6'd0;
        m_seen      = 8'd0;
        m_digits    = 48'd0;
        m_idle      = 1'b1;
        m_seg       = 1'b0;
        m_anerr     = 1'b0;
        m_blank_run = 0;
    endtask

    // A captured digit: decode, close the frame if this slot repeats.
    task automatic model_capture(input int idx, input logic [7:0] cat);
        logic [5:0]  f;
        logic [5:0]  slot;
        logic [47:0] fr;
        logic        bad;
        f   = {1'b1, 4'h0, ~cat[0]};
        bad = 1'b1;
        for (int h = 0; h < 16; h++) begin
            if (glyph[h] == ~cat[7:1]) begin
                f[4:1] = 4'(h);
                bad    = 1'b0;
            end
        end
        if (bad) m_seg = 1'b1;
        m_idle = 1'b0;
        if (m_seen[idx]) begin
            fr = '0;
            for (int i = 0; i < 8; i++) begin
                slot = m_shadow[i];
                if (!m_seen[i]) slot[5] = 1'b0;
                fr[i*6 +: 6] = slot;
            end
            exp_q.push_back({1'b0, fr});
            m_digits    = fr;
            m_seen      = 8'd0;
            m_seen[idx] = 1'b1;
        end else begin
            m_seen[idx] = 1'b1;
        end
        m_shadow[idx] = f;
    endtask

    // One dwell on anode idx: optional glitch samples then len stable samples.
    task automatic do_dwell(input int idx, input logic [7:0] cat, input int glitch, input int len);
        logic [7:0] a;
        logic [7:0] g;
        a = ~(8'b1 << idx);
        if (len >= S) model_capture(idx, cat);
        m_blank_run = 0;
        for (int k = 0; k < glitch; k++) begin
            g = 8'($urandom);
            if (k == glitch - 1 && g == cat) g = ~cat;
            drive(a, g);
        end
        for (int k = 0; k < len; k++) drive(a, cat);
    endtask

    // n cycles with every anode high.
    task automatic do_blank(input int n);
        logic [47:0] fr;
        for (int k = 0; k < n; k++) begin
            m_blank_run++;
            if (m_blank_run == T && !m_idle) begin
                fr = m_digits;
                for (int i = 0; i < 8; i++) fr[i*6 + 5] = 1'b0;
                exp_q.push_back({1'b1, fr});
                m_digits = fr;
                m_seen   = 8'd0;
                m_idle   = 1'b1;
            end
            drive(8'hFF, 8'($urandom));
        end
    endtask

    // One sample with two anodes low.
    task automatic do_anerr(input logic [7:0] a);
        m_anerr     = 1'b1;
        m_blank_run = 0;
        drive(a, 8'($urandom));
    endtask

    // Monitor: every frame_valid pulse consumes one expected frame.
    always @(negedge clock) begin
        logic [48:0] e;
        if (reset && bus.frame_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_frame: got digits %h, no frame expected", bus.digits);
            end else begin
                e = exp_q.pop_front();
                check("frame_digits", 64'(bus.digits), 64'(e[47:0]));
                check("frame_idle", 64'(bus.display_idle), 64'(e[48]));
            end
        end
    end

    initial begin
        logic [7:0] ens;
        logic [7:0] c;
        int         prev;
        int         idx;
        int         len;
        int         glitch;
        int         r;

        glyph = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        model_reset();

        // Reset state
        reset       = 1'b0;
        bus.an      = 8'hFF;
        bus.dec_cat = 8'hFF;
        repeat (3) @(negedge clock);
        check("rst_digits", 64'(bus.digits), 64'd0);
        check("rst_frame_valid", 64'(bus.frame_valid), 64'd0);
        check("rst_seg_error", 64'(bus.seg_error), 64'd0);
        check("rst_anode_error", 64'(bus.anode_error), 64'd0);
        check("rst_display_idle", 64'(bus.display_idle), 64'd1);
        check("rst_fsm_idle", 64'(bus.fsm_state), 64'd0);
        reset = 1'b1;

        // Steady scan d1=3, d2=A, d1 again closes the frame
        do_dwell(7, 8'h0D, 0, 32);
        do_dwell(6, 8'h11, 0, 32);
        do_dwell(7, 8'h0D, 0, 32);
        check("scan_frame", 64'(bus.digits), 64'({6'h26, 6'h34, 36'h0}));
        check("scan_live", 64'(bus.display_idle), 64'd0);

        // Glitch at dwell start, then exactly S stable samples of "5."
        do_dwell(6, glyph_cat(5, 1'b1), 5, S);
        do_dwell(7, 8'h0D, 0, 20);
        check("glitch_d2", 64'(bus.digits[41:36]), 64'(6'h2B));

        // A dwell one sample short is not captured
        do_dwell(5, glyph_cat(1, 1'b0), 2, S - 1);
        do_dwell(6, glyph_cat(9, 1'b0), 0, 20);
        do_dwell(7, 8'h0D, 0, 20);
        check("short_d3_en", 64'(bus.digits[35]), 64'd0);
        check("seg_error_clear", 64'(bus.seg_error), 64'(m_seg));

        // Two anodes low for one cycle
        do_blank(2);
        do_anerr(8'h3F);
        do_blank(2);
        check("anode_error_set", 64'(bus.anode_error), 64'd1);

        // All segments off on d4
        do_dwell(4, 8'hFF, 0, 24);
        do_dwell(7, 8'h0D, 0, 24);
        check("blank_glyph_d4", 64'(bus.digits[29:24]), 64'(6'h20));
        check("seg_error_set", 64'(bus.seg_error), 64'd1);
        check("anode_error_sticky", 64'(bus.anode_error), 64'd1);

        // Idle timeout, then resume
        do_blank(T + 8);
        check("timeout_idle", 64'(bus.display_idle), 64'd1);
        for (int i = 0; i < 8; i++) ens[i] = bus.digits[i*6 + 5];
        check("timeout_en_off", 64'(ens), 64'd0);
        do_dwell(6, glyph_cat(12, 1'b0), 0, 20);
        check("resume_live", 64'(bus.display_idle), 64'd0);

        // Randomized scan
        prev = 6;
        for (int n = 0; n < 120; n++) begin
            do idx = $urandom_range(0, 7); while (idx == prev);
            prev = idx;
            if ($urandom_range(0, 9) == 0) bad_cat(c);
            else c = glyph_cat($urandom_range(0, 15), 1'($urandom));
            r = $urandom_range(0, 9);
            if (r == 0)      len = S - 1;
            else if (r == 1) len = S;
            else if (r == 2) len = $urandom_range(2, S - 2);
            else             len = S + $urandom_range(1, 20);
            glitch = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            do_dwell(idx, c, glitch, len);
            r = $urandom_range(0, 29);
            if (r == 0)      do_blank(T + $urandom_range(0, 10));
            else if (r == 1) do_anerr(~(8'b1 << $urandom_range(0, 3)) & ~(8'b1 << $urandom_range(4, 7)));
            else             do_blank($urandom_range(0, 3));
        end
        do_blank(3);
        check("random_seg_error", 64'(bus.seg_error), 64'(m_seg));
        check("random_anode_error", 64'(bus.anode_error), 64'(m_anerr));

        // Reset midway through a frame
        do_dwell(7, glyph_cat(1, 1'b0), 0, 20);
        do_dwell(6, glyph_cat(2, 1'b0), 0, 20);
        do_blank(2);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("midrst_digits", 64'(bus.digits), 64'd0);
        check("midrst_frame_valid", 64'(bus.frame_valid), 64'd0);
        check("midrst_errors", 64'({bus.seg_error, bus.anode_error}), 64'd0);
        check("midrst_display_idle", 64'(bus.display_idle), 64'd1);
        model_reset();
        exp_q.delete();
        reset = 1'b1;
        do_dwell(7, glyph_cat(4, 1'b0), 0, 20);
        do_dwell(6, glyph_cat(5, 1'b1), 0, 20);
        do_dwell(5, glyph_cat(6, 1'b0), 0, 20);
        do_dwell(7, glyph_cat(4, 1'b0), 0, 20);
        check("rescan_frame", 64'(bus.digits), 64'({6'h28, 6'h2B, 6'h2C, 30'h0}));
        do_blank(3);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
